frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Round-robin scheduler sharing the single serial link between three input buffers. It replaces free-running byte commutation with framed bursts: per grant it emits a header byte, BURST payload bytes pulled from the granted buffer via `read_req`, and an XOR checksum. It sits between the three 16→8 input buffers and the LVDS transmitter, clocked by the transmitter's data clock, and emits a byte every cycle (idle filler when no frame is active).

## Interface
- `BURST`, 8: payload bytes per frame; legal range 2..255.
- `IDLE_BYTE`, 8'hBC: filler byte driven when no frame is active.
- `SYNC`, 4'hA: upper nibble of the header byte.

- `clk`  in  1  single clock; all logic on rising edge.
- `arst`  in  1  reset, synchronous, active-high.
- `input_ready`  in  3  bit i high: buffer i holds at least BURST bytes.
- `ch_enable`  in  3  bit i high: channel i eligible for grant.
- `ch_data`  in  24  buffer read data; ch0 [7:0], ch1 [15:8], ch2 [23:16]; valid the cycle after the matching `read_req`.
- `read_req`  out  3  one-hot read strobe to buffer i; one byte per high cycle.
- `out_data`  out  8  registered byte to LVDS transmitter.
- `out_valid`  out  1  registered; high on header/payload/checksum bytes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cur_ch`  out  2  currently/last granted channel.

## Operation
- States: IDLE, HDR, PAY, CHK. Byte counter `cnt` 8 bit; checksum accumulator `acc` 8 bit.
- Arbitration (in IDLE, and in CHK): eligible = `input_ready & ch_enable`. If nonzero, grant first eligible channel searching from `last+1` mod 3 upward; `last` ← grant; next state HDR. Else IDLE. `last` resets to 2 so ch0 wins first.
- HDR (1 cycle): `read_req[g]`=1; header = {SYNC, 2'b00, g}; `acc` ← header; `cnt` ← 0.
- PAY (BURST cycles): `ch_data[g]` byte is consumed; `acc` ← `acc` ^ byte; `read_req[g]`=1 while `cnt` < BURST-1; `cnt`++; leave to CHK after `cnt` = BURST-1.
- CHK (1 cycle): no read; checksum = `acc`; arbitrate as above (back-to-back frames allowed, no filler between).
- Total reads per frame: exactly BURST (HDR + first BURST-1 PAY cycles).
- `read_req` is a combinational decode of state/`cnt`/grant; never more than one bit high.
- `input_ready`/`ch_enable` sampled only at arbitration; changes mid-frame ignored. `input_ready` dropping mid-frame does not abort (buffer contract guarantees BURST bytes).
- Output register: at edge after state S, `out_data`/`out_valid` = IDLE→(IDLE_BYTE,0), HDR→(header,1), PAY→(`ch_data[g]`,1), CHK→(`acc`,1).

## Timing
- Reset values: state IDLE, `read_req`=0, `out_data`=IDLE_BYTE, `out_valid`=0, `busy`=0, `cur_ch`=2, `cnt`=0, `acc`=0.
- Eligible seen in IDLE cycle t → HDR at t+1 (`read_req` high t+1..t+BURST) → header on `out_data` at t+2, payload t+3..t+BURST+2, checksum t+BURST+3.
- Frame = BURST+2 valid bytes in consecutive cycles; with continuous demand, frames abut with no IDLE_BYTE gap.
- `arst` mid-frame: state IDLE and `read_req`=0 from the next edge; frame truncated with no checksum; `out_data`=IDLE_BYTE, `out_valid`=0 after that edge. Bytes already read from buffers are discarded.
- All three eligible simultaneously: strict rotation 0,1,2,0...; a channel never waits more than two frames while eligible.

## Test plan
- BURST=4, only ch1 ready, buffer bytes 11,22,33,44 → `read_req`=3'b010 for 4 cycles; `out_data` BC, A1, 11, 22, 33, 44, E5 (`out_valid` 0,1×6), then BC.
- All channels ready and enabled continuously, BURST=4 → headers A0, A1, A2, A0 in consecutive frames, 6 valid bytes each, no BC between frames.
- `ch_enable`=3'b101, all ready → grants alternate 0,2,0,2; `read_req[1]` never asserted.
- `arst` asserted in 2nd PAY cycle of a ch0 frame → next cycle `read_req`=0, `busy`=0, `out_valid`=0, `out_data`=BC; after release ch0 (ready) regranted with header A0.
- `input_ready[0]` drops during PAY → frame completes with all BURST bytes and correct checksum.
- No channel ready for 20 cycles → `out_data`=BC, `out_valid`=0, `read_req`=0 throughout.

Source files
------------

// File: rtl/frame_scheduler.sv
// Round-robin framed-burst scheduler: shares one serial byte link between three
// input buffers, emitting header, BURST payload bytes and an XOR checksum per grant.
module frame_scheduler #(
  parameter int unsigned BURST     = 8,
  parameter logic [7:0]  IDLE_BYTE = 8'hBC,
  parameter logic [3:0]  SYNC      = 4'hA
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [2:0]  input_ready,
  input  logic [2:0]  ch_enable,
  input  logic [23:0] ch_data,
  output logic [2:0]  read_req,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic [1:0]  cur_ch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST - 32'd1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] acc_r, acc_s;
  logic [1:0] last_r, last_s;
  logic [2:0] pick_s;
  logic [7:0] byte_s;
  logic [7:0] header_s;

  // Returns {found, channel}: first eligible channel after 'last', wrapping mod 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] c;
    pick = 3'b000;
    c    = last;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!pick[2] && elig[c]) begin
        pick = {1'b1, c};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] ch);
    return 3'b001 << ch;
  endfunction

  assign header_s = {SYNC, 2'b00, last_r};
  assign busy     = (state_r != IDLE);
  assign cur_ch   = last_r;

  // Select the granted channel's byte lane.
  always_comb begin
    byte_s = 8'h00;
    case (last_r)
      2'd0:    byte_s = ch_data[7:0];
      2'd1:    byte_s = ch_data[15:8];
      default: byte_s = ch_data[23:16];
    endcase
  end

  // Next-state, counters, checksum and read strobe decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    last_s   = last_r;
    read_req = 3'b000;
    pick_s   = rr_pick(input_ready & ch_enable, last_r);
    case (state_r)
      IDLE, CHK: begin
        if (pick_s[2]) begin
          state_s = HDR;
          last_s  = pick_s[1:0];
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        read_req = onehot3(last_r);
        acc_s    = header_s;
        cnt_s    = 8'd0;
        state_s  = PAY;
      end
      PAY: begin
        acc_s = csum_step(acc_r, byte_s);
        cnt_s = cnt_r + 8'd1;
        // The final payload byte was already requested in the previous cycle.
        if (cnt_r < LAST_CNT) begin
          read_req = onehot3(last_r);
          state_s  = PAY;
        end else begin
          state_s  = CHK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered link output.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      acc_r     <= 8'd0;
      last_r    <= 2'd2;
      out_data  <= IDLE_BYTE;
      out_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      last_r  <= last_s;
      case (state_r)
        IDLE: begin
          out_data  <= IDLE_BYTE;
          out_valid <= 1'b0;
        end
        HDR: begin
          out_data  <= header_s;
          out_valid <= 1'b1;
        end
        PAY: begin
          out_data  <= byte_s;
          out_valid <= 1'b1;
        end
        CHK: begin
          out_data  <= acc_r;
          out_valid <= 1'b1;
        end
        default: begin
          out_data  <= IDLE_BYTE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a frame-level model predicts every link byte
// and read strobe; a separate monitor compares the link output cycle by cycle.
module tb_frame_scheduler;

  localparam int         BURST = 4;
  localparam logic [7:0] IDLE_B = 8'hBC;

  logic        clk;
  logic        arst;
  logic [2:0]  input_ready;
  logic [2:0]  ch_enable;
  logic [23:0] ch_data;
  logic [2:0]  read_req;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic [1:0]  cur_ch;

  frame_scheduler #(.BURST(BURST), .IDLE_BYTE(8'hBC), .SYNC(4'hA)) dut (
    .clk(clk), .arst(arst), .input_ready(input_ready), .ch_enable(ch_enable),
    .ch_data(ch_data), .read_req(read_req), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .cur_ch(cur_ch)
  );

  typedef struct {
    int unsigned stamp;
    logic        v;
    logic [7:0]  d;
  } item_t;

  item_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned now      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) now <= now + 1;

  // Buffer contents: ch1 starts 11,22,33,44,...
  function automatic logic [7:0] buf_byte(input int ch, input int n);
    return 8'((n + 1) * 17 + (ch - 1) * 64);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, now);
    end
  endtask

  // Buffer responder: serves one byte per read strobe, junk on idle lanes.
  int rptr[3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (arst) begin
        rptr[i] <= 0;
        ch_data[i*8 +: 8] <= 8'($urandom);
      end else if (read_req[i]) begin
        rptr[i] <= rptr[i] + 1;
        ch_data[i*8 +: 8] <= buf_byte(i, rptr[i]);
      end else begin
        ch_data[i*8 +: 8] <= 8'($urandom);
      end
    end
  end

  // Reference model state (frame granularity)
  int unsigned next_arb = 0;
  int unsigned grant_t  = 0;
  int          g_m      = 2;
  int          last_m   = 2;
  bit          prev_end = 1'b0;
  int          mptr[3]  = '{0, 0, 0};

  task automatic push(input int unsigned st, input logic v, input logic [7:0] d);
    item_t it;
    it.stamp = st;
    it.v     = v;
    it.d     = d;
    sb_q.push_back(it);
  endtask

  task automatic model_reset();
    while (sb_q.size() > 0 && sb_q[$].stamp > now) void'(sb_q.pop_back());
    push(now + 1, 1'b0, IDLE_B);
    next_arb = now + 1;
    prev_end = 1'b0;
    last_m   = 2;
    g_m      = 2;
    for (int i = 0; i < 3; i++) mptr[i] = 0;
  endtask

  // Model: at each arbitration point decide the grant and queue the whole frame.
  always @(negedge clk) begin
    logic [2:0] elig;
    logic [7:0] cs;
    logic [7:0] b;
    int         found;
    int         c;
    int unsigned k;
    if (arst) begin
      model_reset();
    end else if (now == next_arb) begin
      chk("read_req_arb", {29'd0, read_req}, 32'd0);
      chk("busy_arb", {31'd0, busy}, {31'd0, prev_end});
      chk("cur_ch_arb", {30'd0, cur_ch}, 32'(last_m));
      if (!prev_end) push(now + 1, 1'b0, IDLE_B);
      elig  = input_ready & ch_enable;
      found = -1;
      for (int off = 1; off <= 3; off++) begin
        c = (last_m + off) % 3;
        if (found < 0 && elig[c]) found = c;
      end
      if (found >= 0) begin
        g_m     = found;
        last_m  = found;
        grant_t = now;
        cs = {4'hA, 2'b00, 2'(found)};
        push(now + 2, 1'b1, cs);
        for (int j = 0; j < BURST; j++) begin
          b  = buf_byte(found, mptr[found] + j);
          cs = cs ^ b;
          push(now + 3 + j, 1'b1, b);
        end
        mptr[found] += BURST;
        push(now + BURST + 3, 1'b1, cs);
        next_arb = now + BURST + 2;
        prev_end = 1'b1;
      end else begin
        next_arb = now + 1;
        prev_end = 1'b0;
      end
    end else begin
      k = now - grant_t;
      chk("read_req", {29'd0, read_req}, (k <= BURST) ? (32'd1 << g_m) : 32'd0);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("cur_ch", {30'd0, cur_ch}, 32'(g_m));
    end
  end

  // Monitor: compare the registered link byte against the scoreboard every cycle.
  bit started = 1'b0;
  always @(negedge clk) begin
    item_t e;
    while (sb_q.size() > 0 && sb_q[0].stamp < now) begin
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL stale_item: expected byte %0h for cycle %0d never compared", e.d, e.stamp);
    end
    if (sb_q.size() > 0 && sb_q[0].stamp == now) begin
      e = sb_q.pop_front();
      started = 1'b1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      chk("out_data", {24'd0, out_data}, {24'd0, e.d});
    end else if (started) begin
      n_checks++;
      n_fail++;
      $display("FAIL no_expect: got %0h with no expected byte at cycle %0d", out_data, now);
    end
  end

  task automatic drive(input logic [2:0] rdy, input logic [2:0] en, input logic rst, input int n);
    input_ready = rdy;
    ch_enable   = en;
    arst        = rst;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    input_ready = 3'b000;
    ch_enable   = 3'b111;
    arst        = 1'b1;
    #1;
    drive(3'b000, 3'b111, 1'b1, 3);
    chk("rst_out_data", {24'd0, out_data}, 32'h0000_00BC);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cur_ch", {30'd0, cur_ch}, 32'd2);
    chk("rst_read_req", {29'd0, read_req}, 32'd0);
    // Single ch1 frame: A1 11 22 33 44 E5
    drive(3'b010, 3'b111, 1'b0, 1);
    drive(3'b000, 3'b111, 1'b0, 10);
    // Continuous demand on all channels: rotation 0,1,2,0
    drive(3'b111, 3'b111, 1'b0, 24);
    drive(3'b000, 3'b111, 1'b0, 8);
    // ch1 disabled: alternate 0,2
    drive(3'b111, 3'b101, 1'b0, 24);
    drive(3'b000, 3'b111, 1'b0, 10);
    // Reset during second payload cycle of a ch0 frame, then regrant
    drive(3'b001, 3'b111, 1'b0, 3);
    drive(3'b001, 3'b111, 1'b1, 1);
    drive(3'b001, 3'b111, 1'b0, 2);
    drive(3'b000, 3'b111, 1'b0, 10);
    // Ready drops mid-frame; frame must still complete
    drive(3'b001, 3'b111, 1'b0, 2);
    drive(3'b000, 3'b111, 1'b0, 10);
    // Long idle stretch
    drive(3'b000, 3'b111, 1'b0, 20);
    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      drive(3'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000),
            3'($urandom_range(0, 7)), ($urandom_range(0, 79) == 0), 1);
    end
    drive(3'b000, 3'b111, 1'b0, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
